mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 130 +++++++++++++
 tb/tb_mem_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Memory initialiser: clears a memory to a fill word, copies a ROM image into it,
// or reads the image region back and flags the first word that differs.
module mem_loader #(
  parameter int               ABITS     = 9,
  parameter int               DBITS     = 16,
  parameter int               IMGLEN    = 38,
  parameter logic [DBITS-1:0] FILL      = '0,
  parameter int               AUTOSTART = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [ABITS-1:0] memaddr,
  output logic [DBITS-1:0] memwdata,
  output logic             memwr,
  output logic             memrd,
  input  logic [DBITS-1:0] memrdata,
  input  logic             memwait,
  output logic [ABITS-1:0] rom_addr,
  input  logic [DBITS-1:0] rom_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ABITS-1:0] err_addr
);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, VERIFY, FIN} state_t;

  localparam logic [1:0]       M_LOAD       = 2'd0;
  localparam logic [1:0]       M_CLEAR_LOAD = 2'd2;
  localparam logic [1:0]       M_VERIFY     = 2'd3;
  localparam logic [ABITS-1:0] LAST_ADDR    = '1;
  localparam logic [ABITS-1:0] LAST_IMG     = ABITS'(IMGLEN - 1);
  localparam state_t           RST_STATE    = (AUTOSTART != 0) ? CLEAR : IDLE;
  localparam logic [1:0]       RST_MODE     = (AUTOSTART != 0) ? M_CLEAR_LOAD : M_LOAD;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic             err_q, err_d;
  logic [ABITS-1:0] err_addr_q, err_addr_d;
  logic             wr_phase, rd_phase, xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      mode_q     <= RST_MODE;
      addr_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    wr_phase   = (state_q == CLEAR) || (state_q == LOAD);
    rd_phase   = (state_q == VERIFY);
    xfer       = (wr_phase || rd_phase) && !memwait;
    state_d    = state_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d     = mode;
          addr_d     = '0;
          err_d      = 1'b0;
          err_addr_d = '0;
          case (mode)
            M_LOAD:   state_d = LOAD;
            M_VERIFY: state_d = VERIFY;
            default:  state_d = CLEAR;
          endcase
        end
      end
      CLEAR: begin
        // Terminal address found by compare so the counter never wraps into a second pass.
        if (xfer) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = (mode_q == M_CLEAR_LOAD) ? LOAD : FIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          if (addr_q == LAST_IMG) state_d = FIN;
          else                    addr_d  = addr_q + 1'b1;
        end
      end
      VERIFY: begin
        if (xfer) begin
          // Only the first mismatch is recorded; the scan always covers the whole image.
          if ((memrdata != rom_data) && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
          end
          if (addr_q == LAST_IMG) state_d = FIN;
          else                    addr_d  = addr_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are gated by rst_n so they drop the instant reset asserts, even when
  // the reset state is CLEAR.
  assign memwr    = rst_n && wr_phase;
  assign memrd    = rst_n && rd_phase;
  assign memaddr  = addr_q;
  assign rom_addr = addr_q;
  assign memwdata = (state_q == CLEAR) ? FILL : rom_data;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: vector table, multi-cycle corner sequences and random operations,
// all checked against a transaction-list model of what the memory bus should carry.
`timescale 1ns/1ps
module tb_mem_loader;
  localparam int AB = 6;
  localparam int DB = 16;
  localparam int IL = 38;
  localparam int NW = 64;
  localparam logic [DB-1:0] FILLV = 16'hC3A5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode  = 2'd0;
  logic          memwait = 1'b0;
  logic [AB-1:0] memaddr, rom_addr, err_addr;
  logic [DB-1:0] memwdata, memrdata, rom_data;
  logic          memwr, memrd, busy, done, err;

  logic [DB-1:0] img [NW];
  logic [DB-1:0] cor [NW];
  logic [DB-1:0] bus_mem [NW];
  logic [DB-1:0] mm [NW];

  always #5 clk = ~clk;

  assign rom_data = img[rom_addr];
  assign memrdata = bus_mem[memaddr] ^ cor[memaddr];

  mem_loader #(.ABITS(AB), .DBITS(DB), .IMGLEN(IL), .FILL(FILLV), .AUTOSTART(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .memaddr(memaddr), .memwdata(memwdata), .memwr(memwr), .memrd(memrd),
    .memrdata(memrdata), .memwait(memwait), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr));

  // Second instance: image fills the whole address space.
  localparam int AB2 = 3;
  localparam int DB2 = 8;
  logic           start2 = 1'b0;
  logic [1:0]     mode2  = 2'd0;
  logic [DB2-1:0] memrdata2 = 8'h00;
  logic           memwait2  = 1'b0;
  logic [AB2-1:0] memaddr2, rom_addr2, err_addr2;
  logic [DB2-1:0] memwdata2, rom_data2;
  logic           memwr2, memrd2, busy2, done2, err2;
  logic [DB2-1:0] img2 [8];

  assign rom_data2 = img2[rom_addr2];

  mem_loader #(.ABITS(AB2), .DBITS(DB2), .IMGLEN(8), .FILL(8'h5A), .AUTOSTART(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2),
    .memaddr(memaddr2), .memwdata(memwdata2), .memwr(memwr2), .memrd(memrd2),
    .memrdata(memrdata2), .memwait(memwait2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .busy(busy2), .done(done2), .err(err2), .err_addr(err_addr2));

  typedef struct packed { logic wr; logic [AB-1:0] a; logic [DB-1:0] d; } xfer_t;

  xfer_t          log_q[$];
  int             hold_q[$];
  int             hold_cnt = 0, done_cnt = 0, both_bad = 0, stab_bad = 0;
  logic           prev_stall = 1'b0;
  logic [AB-1:0]  prev_a = '0;
  logic [DB-1:0]  prev_d = '0;
  logic           prev_wr = 1'b0, prev_rd = 1'b0;
  int             w2_a[$];
  logic [DB2-1:0] w2_d[$];
  int             done2_cnt = 0;

  // Bus monitor: logs completed transfers, updates the bench memory, counts done pulses.
  always @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt   <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (done) done_cnt <= done_cnt + 1;
      if (done2) done2_cnt <= done2_cnt + 1;
      if (memwr && memrd) both_bad <= both_bad + 1;
      if (prev_stall && (memaddr !== prev_a || memwdata !== prev_d ||
                         memwr !== prev_wr || memrd !== prev_rd))
        stab_bad <= stab_bad + 1;
      prev_stall <= (memwr || memrd) && memwait;
      prev_a  <= memaddr;
      prev_d  <= memwdata;
      prev_wr <= memwr;
      prev_rd <= memrd;
      if ((memwr || memrd) && !memwait) begin
        log_q.push_back(xfer_t'({memwr, memaddr, (memwr ? memwdata : {DB{1'b0}})}));
        hold_q.push_back(hold_cnt + 1);
        hold_cnt <= 0;
        if (memwr) bus_mem[memaddr] <= memwdata;
      end else if (memwr || memrd) begin
        hold_cnt <= hold_cnt + 1;
      end
      if (memwr2 && !memwait2) begin
        w2_a.push_back(int'(memaddr2));
        w2_d.push_back(memwdata2);
      end
    end
  end

  // memwait driver: 0 = never stall, 1 = three wait cycles per transfer, 2 = random.
  int stall = 0;
  int wcnt  = 0;
  always @(negedge clk) begin
    if (stall == 1) begin
      if ((memwr || memrd) && wcnt < 3) begin
        memwait <= 1'b1;
        wcnt    <= wcnt + 1;
      end else begin
        memwait <= 1'b0;
        wcnt    <= 0;
      end
    end else if (stall == 2) begin
      memwait <= ($urandom_range(0, 2) == 0);
    end else begin
      memwait <= 1'b0;
    end
  end

  // Reference model: the ordered list of bus transfers an operation must produce.
  xfer_t         exp_q[$];
  logic          exp_err;
  logic [AB-1:0] exp_eaddr;

  task automatic model_op(input logic [1:0] m);
    exp_q.delete();
    exp_err   = 1'b0;
    exp_eaddr = '0;
    if (m == 2'd1 || m == 2'd2)
      for (int a = 0; a < NW; a++) begin
        exp_q.push_back(xfer_t'({1'b1, AB'(a), FILLV}));
        mm[a] = FILLV;
      end
    if (m == 2'd0 || m == 2'd2)
      for (int a = 0; a < IL; a++) begin
        exp_q.push_back(xfer_t'({1'b1, AB'(a), img[a]}));
        mm[a] = img[a];
      end
    if (m == 2'd3)
      for (int a = 0; a < IL; a++) begin
        exp_q.push_back(xfer_t'({1'b0, AB'(a), {DB{1'b0}}}));
        if (!exp_err && ((mm[a] ^ cor[a]) != img[a])) begin
          exp_err   = 1'b1;
          exp_eaddr = AB'(a);
        end
      end
  endtask

  int vectors = 0, miscompares = 0;
  int base = 0, hbase = 0, dbase = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic check_log(input string name, input int b);
    int n = log_q.size() - b;
    int bad = -1;
    check({name, " transfer count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (bad < 0 && log_q[b+i] !== exp_q[i]) bad = i;
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s transfer[%0d]: got wr=%0d a=%0d d=0x%0h, want wr=%0d a=%0d d=0x%0h",
               name, bad, log_q[b+bad].wr, log_q[b+bad].a, log_q[b+bad].d,
               exp_q[bad].wr, exp_q[bad].a, exp_q[bad].d);
    end
  endtask

  task automatic wait_done(input string name, input int inj);
    int n = 0;
    bit busy_ok = 1'b1;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (inj > 0 && n == inj) begin
        start = 1'b1;
        mode  = 2'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({name, " done seen"}, 32'(done === 1'b1), 32'd1);
    check({name, " busy held"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({name, " done low after pulse"}, 32'(done), 32'd0);
    check({name, " done pulses"}, 32'(done_cnt - dbase), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] m, input int st, input int inj);
    stall = st;
    model_op(m);
    base  = log_q.size();
    hbase = hold_q.size();
    dbase = done_cnt;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    wait_done(name, inj);
    check_log(name, base);
    check({name, " err"}, 32'(err), 32'(exp_err));
    check({name, " err_addr"}, 32'(err_addr), 32'(exp_eaddr));
  endtask

  typedef struct {
    logic [1:0] m;
    int st;
    int c1;
    int c2;
    logic e;
    int ea;
    int nwr;
    int nrd;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n, bad, nwr, nrd;
    logic [1:0] rm;

    tbl[0] = '{2'd3, 0, -1, -1, 1'b0, 0,  0,   38};
    tbl[1] = '{2'd3, 0,  5,  9, 1'b1, 5,  0,   38};
    tbl[2] = '{2'd0, 1, -1, -1, 1'b0, 0,  38,  0};
    tbl[3] = '{2'd1, 0, -1, -1, 1'b0, 0,  64,  0};
    tbl[4] = '{2'd3, 2, -1, -1, 1'b1, 0,  0,   38};
    tbl[5] = '{2'd2, 2, -1, -1, 1'b0, 0,  102, 0};
    tbl[6] = '{2'd3, 1, 37, -1, 1'b1, 37, 0,   38};

    for (int a = 0; a < NW; a++) begin
      img[a] = DB'($urandom);
      if (img[a] == FILLV) img[a] = img[a] ^ 16'h0001;
      cor[a] = '0;
    end
    for (int a = 0; a < 8; a++) img2[a] = DB2'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset memaddr", 32'(memaddr), 32'd0);
    check("reset memwr", 32'(memwr), 32'd0);
    check("reset memrd", 32'(memrd), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset err_addr", 32'(err_addr), 32'd0);

    // Automatic clear+load after reset release
    stall = 0;
    model_op(2'd2);
    base  = log_q.size();
    dbase = done_cnt;
    rst_n = 1'b1;
    wait_done("autostart", 0);
    check_log("autostart", base);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      for (int a = 0; a < NW; a++) cor[a] = '0;
      if (tbl[i].c1 >= 0) cor[tbl[i].c1] = 16'h0100;
      if (tbl[i].c2 >= 0) cor[tbl[i].c2] = 16'h0003;
      run_op($sformatf("vec%0d", i), tbl[i].m, tbl[i].st, 0);
      nwr = 0;
      nrd = 0;
      for (int j = base; j < log_q.size(); j++)
        if (log_q[j].wr) nwr++; else nrd++;
      check($sformatf("vec%0d table err", i), 32'(err), 32'(tbl[i].e));
      if (tbl[i].e) check($sformatf("vec%0d table err_addr", i), 32'(err_addr), 32'(tbl[i].ea));
      check($sformatf("vec%0d table writes", i), 32'(nwr), 32'(tbl[i].nwr));
      check($sformatf("vec%0d table reads", i), 32'(nrd), 32'(tbl[i].nrd));
      if (tbl[i].st == 1) begin
        bad = 0;
        for (int j = hbase; j < hold_q.size(); j++) if (hold_q[j] != 4) bad++;
        check($sformatf("vec%0d cycles per address", i), 32'(bad), 32'd0);
      end
    end

    // start during LOAD is ignored; the next start begins again at address 0
    for (int a = 0; a < NW; a++) cor[a] = '0;
    run_op("start_in_load", 2'd0, 0, 10);
    run_op("after_restart", 2'd3, 0, 0);

    // Reset in the middle of LOAD
    stall = 0;
    dbase = done_cnt;
    @(negedge clk);
    start = 1'b1;
    mode  = 2'd0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(memwr === 1'b1 && memaddr == AB'(20)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort reached addr 20", 32'(memaddr), 32'd20);
    rst_n = 1'b0;
    #1;
    check("abort memaddr", 32'(memaddr), 32'd0);
    check("abort memwr", 32'(memwr), 32'd0);
    check("abort memrd", 32'(memrd), 32'd0);
    check("abort done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("abort no done pulse", 32'(done_cnt - dbase), 32'd0);
    model_op(2'd2);
    base  = log_q.size();
    dbase = done_cnt;
    rst_n = 1'b1;
    wait_done("abort restart", 0);
    check_log("abort restart", base);

    // Random operations against the model
    for (int k = 0; k < 10; k++) begin
      rm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        for (int a = 0; a < NW; a++) img[a] = DB'($urandom);
      for (int a = 0; a < NW; a++) cor[a] = '0;
      if ($urandom_range(0, 1) == 1) cor[$urandom_range(0, IL - 1)] = DB'($urandom_range(1, 65535));
      run_op($sformatf("rnd%0d", k), rm, int'($urandom_range(0, 2)), 0);
    end

    // Image spanning the whole address space: no wrap past the top address
    @(negedge clk);
    start2 = 1'b1;
    mode2  = 2'd0;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("full image done", 32'(done2 === 1'b1), 32'd1);
    repeat (3) @(negedge clk);
    check("full image writes", 32'(w2_a.size()), 32'd8);
    bad = 0;
    for (int i = 0; i < w2_a.size(); i++)
      if (w2_a[i] != i || w2_d[i] !== img2[i]) bad++;
    check("full image order", 32'(bad), 32'd0);
    check("full image done pulses", 32'(done2_cnt), 32'd1);

    check("memwr and memrd together", 32'(both_bad), 32'd0);
    check("bus stable under memwait", 32'(stab_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
